// File: rtl/jstk2_spi_reader.sv
// jstk2_spi_reader
//   SPI master (mode 0) that polls a PmodJSTK2 joystick with a fixed 5-byte
//   "get position" frame. It publishes the decoded X/Y position and the two
//   button bits together, with a one-cycle valid strobe.
//
// Ports
//   clk     in   1   system clock
//   rst     in   1   synchronous, active-high reset
//   enable  in   1   1 = poll continuously; 0 = finish current frame, then idle
//   miso    in   1   SPI data from joystick
//   sclk    out  1   SPI clock, idle low
//   mosi    out  1   SPI data to joystick, MSB first
//   cs_n    out  1   SPI chip select, active low
//   xpos    out  10  last decoded X position
//   ypos    out  10  last decoded Y position
//   button  out  2   last decoded buttons: [0] stick press, [1] trigger
//   valid   out  1   one-cycle pulse when xpos/ypos/button update
//   busy    out  1   high from cs_n fall until the cs_n idle time completes
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for enable; next cycle starts a frame
// CS_SETUP   | cs_n low, sclk low, mosi holds MSB of byte 0
// SHIFT      | clocking bits: SCLK_HALF low, then SCLK_HALF high per bit
// GAP        | inter-byte pause after bytes 0-3, sclk low, cs_n low
// CS_IDLE    | cs_n high for CS_IDLE_CYC after a frame, busy still high
// WAIT       | holding off until the poll period since last cs_n fall ends
module jstk2_spi_reader #(
    parameter int SCLK_HALF       = 12,
    parameter int CS_SETUP_CYC    = 180,
    parameter int BYTE_GAP_CYC    = 120,
    parameter int CS_IDLE_CYC     = 300,
    parameter int POLL_PERIOD_CYC = 120000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic [1:0] button,
    output logic       valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_CS_IDLE,
        ST_WAIT
    } state_t;

    localparam int MAX_A   = (CS_SETUP_CYC > CS_IDLE_CYC) ? CS_SETUP_CYC : CS_IDLE_CYC;
    localparam int MAX_B   = (BYTE_GAP_CYC > SCLK_HALF) ? BYTE_GAP_CYC : SCLK_HALF;
    localparam int TMR_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int POLL_W  = $clog2(POLL_PERIOD_CYC + 1);

    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(CS_SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] HALF_LOAD  = TMR_W'(SCLK_HALF - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(BYTE_GAP_CYC - 1);
    localparam logic [TMR_W-1:0] IDLE_LOAD  = TMR_W'(CS_IDLE_CYC - 1);

    localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_PERIOD_CYC);
    // Two cycles early: one for the WAIT->IDLE hop and one for IDLE->CS_SETUP,
    // so successive cs_n falls land exactly POLL_PERIOD_CYC apart.
    localparam logic [POLL_W-1:0] POLL_EXP = POLL_W'(POLL_PERIOD_CYC - 2);

    localparam logic [7:0] CMD_BYTE = 8'hC0;

    // Command frame is CMD_BYTE followed by four zero bytes; bit_idx 0 is the MSB.
    function automatic logic tx_bit(input logic [2:0] byte_idx, input logic [2:0] bit_idx);
        logic [7:0] b;
        b = (byte_idx == 3'd0) ? CMD_BYTE : 8'h00;
        return b[3'd7 - bit_idx];
    endfunction

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic [POLL_W-1:0]  poll_cnt, poll_nxt;
    logic [3:0]         bit_cnt, bit_nxt;
    logic [2:0]         byte_cnt, byte_nxt;
    logic [39:0]        rx, rx_nxt;
    logic               enable_q;
    logic               sclk_nxt, mosi_nxt, cs_n_nxt, valid_nxt, busy_nxt;
    logic [9:0]         xpos_nxt, ypos_nxt;
    logic [1:0]         button_nxt;
    logic               frame_start;
    logic               tmr_done;
    logic               poll_expired;

    assign tmr_done     = (tmr == '0);
    assign poll_expired = (poll_cnt >= POLL_EXP);

    always_comb begin
        state_nxt   = state;
        tmr_nxt     = tmr;
        bit_nxt     = bit_cnt;
        byte_nxt    = byte_cnt;
        rx_nxt      = rx;
        sclk_nxt    = sclk;
        mosi_nxt    = mosi;
        cs_n_nxt    = cs_n;
        xpos_nxt    = xpos;
        ypos_nxt    = ypos;
        button_nxt  = button;
        valid_nxt   = 1'b0;
        busy_nxt    = busy;
        frame_start = 1'b0;

        case (state)
            ST_IDLE: begin
                if (enable_q) begin
                    state_nxt   = ST_CS_SETUP;
                    cs_n_nxt    = 1'b0;
                    busy_nxt    = 1'b1;
                    mosi_nxt    = tx_bit(3'd0, 3'd0);
                    tmr_nxt     = SETUP_LOAD;
                    bit_nxt     = 4'd0;
                    byte_nxt    = 3'd0;
                    frame_start = 1'b1;
                end
            end
            ST_CS_SETUP: begin
                if (tmr_done) begin
                    state_nxt = ST_SHIFT;
                    tmr_nxt   = HALF_LOAD;
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            ST_SHIFT: begin
                if (!tmr_done) begin
                    tmr_nxt = tmr - TMR_ONE;
                end else if (!sclk) begin
                    // bit_cnt == 8 marks the trailing low phase after the last byte
                    if (bit_cnt == 4'd8) begin
                        state_nxt  = ST_CS_IDLE;
                        cs_n_nxt   = 1'b1;
                        tmr_nxt    = IDLE_LOAD;
                        valid_nxt  = 1'b1;
                        xpos_nxt   = {rx[25:24], rx[39:32]};
                        ypos_nxt   = {rx[9:8], rx[23:16]};
                        button_nxt = rx[1:0];
                    end else begin
                        sclk_nxt = 1'b1;
                        rx_nxt   = {rx[38:0], miso};
                        tmr_nxt  = HALF_LOAD;
                    end
                end else begin
                    sclk_nxt = 1'b0;
                    tmr_nxt  = HALF_LOAD;
                    if (bit_cnt == 4'd7) begin
                        if (byte_cnt == 3'd4) begin
                            bit_nxt = 4'd8;
                        end else begin
                            state_nxt = ST_GAP;
                            tmr_nxt   = GAP_LOAD;
                        end
                    end else begin
                        bit_nxt  = bit_cnt + 4'd1;
                        mosi_nxt = tx_bit(byte_cnt, bit_cnt[2:0] + 3'd1);
                    end
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    state_nxt = ST_SHIFT;
                    tmr_nxt   = HALF_LOAD;
                    bit_nxt   = 4'd0;
                    byte_nxt  = byte_cnt + 3'd1;
                    mosi_nxt  = tx_bit(byte_cnt + 3'd1, 3'd0);
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            ST_CS_IDLE: begin
                if (tmr_done) begin
                    state_nxt = ST_WAIT;
                    busy_nxt  = 1'b0;
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            ST_WAIT: begin
                if (poll_expired) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (frame_start) begin
            poll_nxt = '0;
        end else if (poll_cnt == POLL_MAX) begin
            poll_nxt = poll_cnt;
        end else begin
            poll_nxt = poll_cnt + POLL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tmr      <= '0;
            poll_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rx       <= '0;
            enable_q <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            xpos     <= '0;
            ypos     <= '0;
            button   <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            poll_cnt <= poll_nxt;
            bit_cnt  <= bit_nxt;
            byte_cnt <= byte_nxt;
            rx       <= rx_nxt;
            enable_q <= enable;
            sclk     <= sclk_nxt;
            mosi     <= mosi_nxt;
            cs_n     <= cs_n_nxt;
            xpos     <= xpos_nxt;
            ypos     <= ypos_nxt;
            button   <= button_nxt;
            valid    <= valid_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_jstk2_spi_reader.sv
// Self-checking bench for jstk2_spi_reader: joystick slave model, SPI timing
// monitor and a byte-level decode model. Poll period is shortened so the run
// stays short; all other timing parameters keep their default values.
module tb_jstk2_spi_reader;

    localparam int POLL      = 3000;
    localparam int BYTE_GAP  = 120;
    localparam int CS_IDLE   = 300;
    localparam int BUDGET    = 8000;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       miso = 1'b0;
    logic       sclk, mosi, cs_n, valid, busy;
    logic [9:0] xpos, ypos;
    logic [1:0] button;

    int n_tests = 0;
    int n_fail  = 0;

    jstk2_spi_reader #(
        .SCLK_HALF(12),
        .CS_SETUP_CYC(180),
        .BYTE_GAP_CYC(BYTE_GAP),
        .CS_IDLE_CYC(CS_IDLE),
        .POLL_PERIOD_CYC(POLL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .miso(miso),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .xpos(xpos), .ypos(ypos), .button(button),
        .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Slave model and SPI monitor, sampled on the falling clk edge.
    logic [39:0] slave_tx = '0;
    logic [39:0] slave_loaded = '0;
    logic [39:0] slave_sr = '0;
    logic [39:0] mosi_cap = '0;
    logic        cs_q = 1'b1;
    logic        sclk_q = 1'b0;
    int fall_cnt = 0, rise_cnt = 0, bad_period = 0, min_gap_low = 0, low_run = 0;
    int first_rise_dly = 0, last_fall_cyc = 0, last_rise_cyc = 0, last_csr_cyc = 0;
    int spacing = 0, high_len = 0, valid_cnt = 0;

    always @(negedge clk) begin
        if (cs_q && !cs_n) begin
            fall_cnt++;
            spacing       = cyc - last_fall_cyc;
            high_len      = cyc - last_csr_cyc;
            last_fall_cyc = cyc;
            rise_cnt      = 0;
            bad_period    = 0;
            min_gap_low   = 1 << 30;
            low_run       = 0;
            mosi_cap      = '0;
            slave_loaded  = slave_tx;
            slave_sr      = slave_tx;
            miso          = slave_sr[39];
        end
        if (!cs_q && cs_n) last_csr_cyc = cyc;
        if (!cs_n) begin
            if (!sclk_q && sclk) begin
                rise_cnt++;
                mosi_cap = {mosi_cap[38:0], mosi};
                if (rise_cnt == 1) begin
                    first_rise_dly = cyc - last_fall_cyc;
                end else begin
                    if (cyc - last_rise_cyc != ((rise_cnt % 8 == 1) ? 144 : 24)) bad_period++;
                    if (rise_cnt % 8 == 1 && low_run < min_gap_low) min_gap_low = low_run;
                end
                last_rise_cyc = cyc;
                low_run = 0;
            end else if (!sclk) begin
                low_run++;
            end
            if (sclk_q && !sclk) begin
                slave_sr = {slave_sr[38:0], 1'b0};
                miso     = slave_sr[39];
            end
        end
        if (valid) valid_cnt++;
        cs_q   = cs_n;
        sclk_q = sclk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_decode(input logic [39:0] f, output int x, output int y, output int btn);
        int b[5];
        for (int i = 0; i < 5; i++) b[i] = int'((f >> (8 * (4 - i))) & 40'hFF);
        x   = b[0] + 256 * (b[1] % 4);
        y   = b[2] + 256 * (b[3] % 4);
        btn = b[4] % 4;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_fall();
        int f0;
        bit ok;
        f0 = fall_cnt;
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk); #1;
            if (fall_cnt != f0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("cs_fall_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rises(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk); #1;
            if (rise_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("rise_timeout", 64'd0, 64'd1);
    endtask

    // Waits for the end of the current frame and checks the decoded outputs.
    task automatic check_frame(input string tag);
        bit ok;
        int x, y, btn;
        wait_valid(ok);
        if (ok) begin
            model_decode(slave_loaded, x, y, btn);
            check_eq({tag, "_xpos"}, 64'(xpos), 64'(x));
            check_eq({tag, "_ypos"}, 64'(ypos), 64'(y));
            check_eq({tag, "_button"}, 64'(button), 64'(btn));
            check_eq({tag, "_cs_n_at_valid"}, 64'(cs_n), 64'd1);
            check_eq({tag, "_rises"}, 64'(rise_cnt), 64'd40);
            @(posedge clk); #1;
            check_eq({tag, "_valid_one_cycle"}, 64'(valid), 64'd0);
        end
    endtask

    initial begin
        int v0, f0;
        rst      = 1'b1;
        enable   = 1'b0;
        slave_tx = 40'h34_02_C8_01_03;

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_cs_n", 64'(cs_n), 64'd1);
        check_eq("rst_sclk", 64'(sclk), 64'd0);
        check_eq("rst_valid", 64'(valid), 64'd0);
        check_eq("rst_xpos", 64'(xpos), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_holds_cs_n", 64'(cs_n), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("start_idle_cs_n", 64'(cs_n), 64'd1);
        @(posedge clk); #1;
        check_eq("start_fall_cs_n", 64'(cs_n), 64'd0);
        check_eq("start_busy", 64'(busy), 64'd1);
        check_eq("start_mosi_msb", 64'(mosi), 64'd1);

        // Known frame plus SPI timing
        check_frame("frame_a");
        check_eq("frame_a_xpos_const", 64'(xpos), 64'h234);
        check_eq("frame_a_ypos_const", 64'(ypos), 64'h1C8);
        check_eq("frame_a_button_const", 64'(button), 64'h3);
        check_eq("frame_a_mosi_bytes", 64'(mosi_cap), 64'hC0_00_00_00_00);
        check_eq("first_rise_delay", 64'(first_rise_dly), 64'd192);
        check_eq("sclk_period", 64'(bad_period), 64'd0);
        check_eq("gap_low_min", 64'(min_gap_low >= BYTE_GAP), 64'd1);

        // Unused high bits set
        slave_tx = 40'h5A_FE_77_FD_FC;
        check_frame("frame_b");
        check_eq("frame_b_xhi", 64'(xpos[9:8]), 64'h2);
        check_eq("frame_b_yhi", 64'(ypos[9:8]), 64'h1);
        check_eq("frame_b_button", 64'(button), 64'h0);
        check_eq("poll_spacing", 64'(spacing), 64'(POLL));
        check_eq("cs_high_min", 64'(high_len >= CS_IDLE), 64'd1);

        // Random frames
        for (int i = 0; i < 5; i++) begin
            slave_tx = {32'($urandom), 8'($urandom_range(0, 255))};
            check_frame("rand");
            check_eq("rand_spacing", 64'(spacing), 64'(POLL));
            check_eq("rand_mosi_bytes", 64'(mosi_cap), 64'hC0_00_00_00_00);
        end

        // Drop enable during byte 2
        slave_tx = 40'hA5_01_3C_02_01;
        wait_fall();
        wait_rises(18);
        enable = 1'b0;
        v0 = valid_cnt;
        check_frame("en_drop");
        f0 = fall_cnt;
        repeat (10000) @(posedge clk);
        #1;
        check_eq("en_drop_no_restart", 64'(fall_cnt), 64'(f0));
        check_eq("en_drop_one_valid", 64'(valid_cnt), 64'(v0 + 1));
        check_eq("en_drop_cs_n", 64'(cs_n), 64'd1);
        check_eq("en_drop_busy", 64'(busy), 64'd0);

        // Reset pulse during byte 3
        slave_tx = 40'h11_03_22_03_02;
        enable   = 1'b1;
        wait_fall();
        wait_rises(26);
        slave_tx = 40'h9C_02_E7_01_01;
        v0  = valid_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_cs_n", 64'(cs_n), 64'd1);
        check_eq("midrst_sclk", 64'(sclk), 64'd0);
        check_eq("midrst_xpos", 64'(xpos), 64'd0);
        check_eq("midrst_valid", 64'(valid), 64'd0);
        @(posedge clk); #1;
        check_eq("midrst_idle_cs_n", 64'(cs_n), 64'd1);
        @(posedge clk); #1;
        check_eq("midrst_restart_cs_n", 64'(cs_n), 64'd0);
        check_eq("midrst_no_partial_valid", 64'(valid_cnt), 64'(v0));
        check_frame("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
